// File: rtl/calc_control_gen.sv
// Key-to-control sequencer for a two-operand calculator.
// Keys are one-cycle pulses. The highest-priority asserted key is decoded against
// the current state into Mealy strobes for the datapath. The state, the digit
// counter and the memory-valid flag advance on the following rising edge.
// Ports:
//   clock, reset_n             clock; asynchronous active-low reset
//   clear_in .. mc_in          key pulses; priority clear > mc > mr > ms > ex > op > dig > sub > bksp
//   err_in                     datapath error, sampled only while in EXEC
//   load_A .. clear_regs       combinational datapath strobes
//   state_led                  current state encoding
//   display_select             00 A, 01 B, 10 result, 11 error
//   digit_count                digits held by the operand being entered
//   mem_valid                  memory holds a stored result
//   error                      high only in ERROR
module calc_control_gen #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_in,
  input  logic             dig_in,
  input  logic             sub_in,
  input  logic             op_in,
  input  logic             ex_in,
  input  logic             bksp_in,
  input  logic             ms_in,
  input  logic             mr_in,
  input  logic             mc_in,
  input  logic             err_in,
  output logic             load_A,
  output logic             load_B,
  output logic             bksp_A,
  output logic             bksp_B,
  output logic             neg_A,
  output logic             neg_B,
  output logic             load_op,
  output logic             execute,
  output logic             load_A_from_result,
  output logic             mem_store,
  output logic             mem_recall_A,
  output logic             mem_recall_B,
  output logic             mem_clear,
  output logic             clear_regs,
  output logic [3:0]       state_led,
  output logic [1:0]       display_select,
  output logic [CNT_W-1:0] digit_count,
  output logic             mem_valid,
  output logic             error
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_OP_A   = 4'd1,
    ST_A_NEG  = 4'd2,
    ST_OPRND  = 4'd3,
    ST_OP_B   = 4'd4,
    ST_B_NEG  = 4'd5,
    ST_RESULT = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ERROR  = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_valid_q, mem_valid_d;
  // Low during reset and for the first cycle after release, which masks keys
  // that coincide with reset deassertion. Because it clears asynchronously,
  // it also forces every strobe low while reset_n is held low.
  logic             armed_q;
  // High when ordinary keys may be acted on. ERROR responds only to clear,
  // and EXEC always advances on its own.
  logic             keys_live;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_START;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      armed_q     <= 1'b1;
    end
  end

  assign keys_live = armed_q && (state_q != ST_ERROR) && (state_q != ST_EXEC);

  // Next-state and strobe decode; a key that is invalid in the current state gives a no-op cycle
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    mem_valid_d        = mem_valid_q;
    load_A             = 1'b0;
    load_B             = 1'b0;
    bksp_A             = 1'b0;
    bksp_B             = 1'b0;
    neg_A              = 1'b0;
    neg_B              = 1'b0;
    load_op            = 1'b0;
    execute            = 1'b0;
    load_A_from_result = 1'b0;
    mem_store          = 1'b0;
    mem_recall_A       = 1'b0;
    mem_recall_B       = 1'b0;
    mem_clear          = 1'b0;
    clear_regs         = 1'b0;

    if (armed_q && clear_in) begin
      clear_regs = 1'b1;
      state_d    = ST_START;
      cnt_d      = '0;
    end else if (state_q == ST_EXEC) begin
      // Single-cycle state: all keys apart from clear are ignored, including mc
      state_d = err_in ? ST_ERROR : ST_RESULT;
    end else if (keys_live) begin
      if (mc_in) begin
        mem_clear   = 1'b1;
        mem_valid_d = 1'b0;
      end else if (mr_in) begin
        if (mem_valid_q) begin
          case (state_q)
            ST_START: begin
              mem_recall_A = 1'b1;
              state_d      = ST_OP_A;
              cnt_d        = CntMax;
            end
            ST_OPRND: begin
              mem_recall_B = 1'b1;
              state_d      = ST_OP_B;
              cnt_d        = CntMax;
            end
            default: ;
          endcase
        end
      end else if (ms_in) begin
        if (state_q == ST_RESULT) begin
          mem_store   = 1'b1;
          mem_valid_d = 1'b1;
        end
      end else if (ex_in) begin
        if (state_q == ST_OP_B) begin
          execute = 1'b1;
          state_d = ST_EXEC;
        end
      end else if (op_in) begin
        case (state_q)
          ST_OP_A: begin
            load_op = 1'b1;
            state_d = ST_OPRND;
            cnt_d   = '0;
          end
          ST_RESULT: begin
            // Chain off the previous result: it becomes operand A
            load_A_from_result = 1'b1;
            load_op            = 1'b1;
            state_d            = ST_OPRND;
            cnt_d              = '0;
          end
          default: ;
        endcase
      end else if (dig_in) begin
        case (state_q)
          ST_START, ST_A_NEG: begin
            load_A  = 1'b1;
            state_d = ST_OP_A;
            cnt_d   = CntOne;
          end
          ST_OPRND, ST_B_NEG: begin
            load_B  = 1'b1;
            state_d = ST_OP_B;
            cnt_d   = CntOne;
          end
          ST_OP_A: begin
            if (cnt_q < CntMax) begin
              load_A = 1'b1;
              cnt_d  = cnt_q + CntOne;
            end
          end
          ST_OP_B: begin
            if (cnt_q < CntMax) begin
              load_B = 1'b1;
              cnt_d  = cnt_q + CntOne;
            end
          end
          default: ;
        endcase
      end else if (sub_in) begin
        // Sign toggles before the first digit of either operand
        case (state_q)
          ST_START: begin
            neg_A   = 1'b1;
            state_d = ST_A_NEG;
          end
          ST_A_NEG: begin
            neg_A   = 1'b1;
            state_d = ST_START;
          end
          ST_OPRND: begin
            neg_B   = 1'b1;
            state_d = ST_B_NEG;
          end
          ST_B_NEG: begin
            neg_B   = 1'b1;
            state_d = ST_OPRND;
          end
          default: ;
        endcase
      end else if (bksp_in) begin
        // Removing the last digit returns to the pre-entry state
        case (state_q)
          ST_OP_A: begin
            if (cnt_q != '0) begin
              bksp_A = 1'b1;
              cnt_d  = cnt_q - CntOne;
              if (cnt_q == CntOne) state_d = ST_START;
            end
          end
          ST_OP_B: begin
            if (cnt_q != '0) begin
              bksp_B = 1'b1;
              cnt_d  = cnt_q - CntOne;
              if (cnt_q == CntOne) state_d = ST_OPRND;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    display_select = 2'b00;
    case (state_q)
      ST_B_NEG, ST_OP_B, ST_EXEC: display_select = 2'b01;
      ST_RESULT:                  display_select = 2'b10;
      ST_ERROR:                   display_select = 2'b11;
      default:                    display_select = 2'b00;
    endcase
  end

  assign state_led   = state_q;
  assign digit_count = cnt_q;
  assign mem_valid   = mem_valid_q;
  assign error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_calc_control_gen.sv
module tb_calc_control_gen;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned CNT_W  = 4;

  // Key bit positions; a higher index means a higher priority
  localparam int K_BK = 0, K_SUB = 1, K_DIG = 2, K_OP = 3, K_EX = 4;
  localparam int K_MS = 5, K_MR = 6, K_MC = 7, K_CLR = 8;

  // State values as numbered in the requirements
  localparam int S_START = 0, S_OPA = 1, S_ANEG = 2, S_OPRND = 3, S_OPB = 4;
  localparam int S_BNEG = 5, S_RES = 6, S_EXEC = 7, S_ERR = 8;

  // Strobe bit positions in the packed observation vector
  localparam int B_LA = 0, B_LB = 1, B_BA = 2, B_BB = 3, B_NA = 4, B_NB = 5, B_LOP = 6;
  localparam int B_EX = 7, B_LAR = 8, B_MS = 9, B_RA = 10, B_RB = 11, B_MC = 12, B_CLR = 13;

  logic clock;
  logic reset_n;
  logic clear_in, dig_in, sub_in, op_in, ex_in, bksp_in, ms_in, mr_in, mc_in, err_in;
  logic load_A, load_B, bksp_A, bksp_B, neg_A, neg_B, load_op, execute;
  logic load_A_from_result, mem_store, mem_recall_A, mem_recall_B, mem_clear, clear_regs;
  logic [3:0]       state_led;
  logic [1:0]       display_select;
  logic [CNT_W-1:0] digit_count;
  logic             mem_valid;
  logic             error;

  int total;
  int bad;

  // Reference model
  int m_state;
  int m_cnt;
  bit m_memv;

  calc_control_gen #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .clear_in(clear_in), .dig_in(dig_in), .sub_in(sub_in), .op_in(op_in), .ex_in(ex_in),
    .bksp_in(bksp_in), .ms_in(ms_in), .mr_in(mr_in), .mc_in(mc_in), .err_in(err_in),
    .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A), .bksp_B(bksp_B),
    .neg_A(neg_A), .neg_B(neg_B), .load_op(load_op), .execute(execute),
    .load_A_from_result(load_A_from_result), .mem_store(mem_store),
    .mem_recall_A(mem_recall_A), .mem_recall_B(mem_recall_B),
    .mem_clear(mem_clear), .clear_regs(clear_regs),
    .state_led(state_led), .display_select(display_select),
    .digit_count(digit_count), .mem_valid(mem_valid), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] key(input int k);
    logic [8:0] one;
    one = 9'd1;
    return one << k;
  endfunction

  function automatic logic [13:0] obs_strobes();
    return {clear_regs, mem_clear, mem_recall_B, mem_recall_A, mem_store, load_A_from_result,
            execute, load_op, neg_B, neg_A, bksp_B, bksp_A, load_B, load_A};
  endfunction

  function automatic logic [1:0] exp_disp(input int s);
    if (s == S_ERR) return 2'b11;
    if (s == S_RES) return 2'b10;
    if (s == S_BNEG || s == S_OPB || s == S_EXEC) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input logic [8:0] k, input logic err);
    clear_in = k[K_CLR]; mc_in = k[K_MC]; mr_in = k[K_MR]; ms_in = k[K_MS];
    ex_in = k[K_EX]; op_in = k[K_OP]; dig_in = k[K_DIG]; sub_in = k[K_SUB];
    bksp_in = k[K_BK]; err_in = err;
  endtask

  task automatic model_reset();
    m_state = S_START;
    m_cnt   = 0;
    m_memv  = 1'b0;
  endtask

  // One key cycle: drive at negedge, check Mealy strobes and state, then let the edge commit
  task automatic step(input logic [8:0] k, input logic err);
    int top;
    int ns, nc;
    bit nm;
    logic [13:0] es;
    @(negedge clock);
    drive(k, err);
    #2;
    top = -1;
    for (int i = 0; i < 9; i++) if (k[i]) top = i;
    ns = m_state; nc = m_cnt; nm = m_memv; es = '0;
    if (top == K_CLR) begin
      es[B_CLR] = 1'b1; ns = S_START; nc = 0;
    end else if (m_state == S_EXEC) begin
      ns = err ? S_ERR : S_RES;
    end else if (m_state != S_ERR) begin
      case (top)
        K_MC: begin es[B_MC] = 1'b1; nm = 1'b0; end
        K_MR: if (m_memv) begin
          if (m_state == S_START) begin es[B_RA] = 1'b1; ns = S_OPA; nc = DIGITS; end
          if (m_state == S_OPRND) begin es[B_RB] = 1'b1; ns = S_OPB; nc = DIGITS; end
        end
        K_MS: if (m_state == S_RES) begin es[B_MS] = 1'b1; nm = 1'b1; end
        K_EX: if (m_state == S_OPB) begin es[B_EX] = 1'b1; ns = S_EXEC; end
        K_OP: begin
          if (m_state == S_OPA) begin es[B_LOP] = 1'b1; ns = S_OPRND; nc = 0; end
          if (m_state == S_RES) begin
            es[B_LOP] = 1'b1; es[B_LAR] = 1'b1; ns = S_OPRND; nc = 0;
          end
        end
        K_DIG: begin
          if (m_state == S_START || m_state == S_ANEG) begin es[B_LA] = 1'b1; ns = S_OPA; nc = 1; end
          if (m_state == S_OPRND || m_state == S_BNEG) begin es[B_LB] = 1'b1; ns = S_OPB; nc = 1; end
          if (m_state == S_OPA && m_cnt < DIGITS) begin es[B_LA] = 1'b1; nc = m_cnt + 1; end
          if (m_state == S_OPB && m_cnt < DIGITS) begin es[B_LB] = 1'b1; nc = m_cnt + 1; end
        end
        K_SUB: begin
          if (m_state == S_START) begin es[B_NA] = 1'b1; ns = S_ANEG; end
          if (m_state == S_ANEG)  begin es[B_NA] = 1'b1; ns = S_START; end
          if (m_state == S_OPRND) begin es[B_NB] = 1'b1; ns = S_BNEG; end
          if (m_state == S_BNEG)  begin es[B_NB] = 1'b1; ns = S_OPRND; end
        end
        K_BK: begin
          if (m_state == S_OPA) begin
            es[B_BA] = 1'b1; nc = m_cnt - 1; if (m_cnt == 1) ns = S_START;
          end
          if (m_state == S_OPB) begin
            es[B_BB] = 1'b1; nc = m_cnt - 1; if (m_cnt == 1) ns = S_OPRND;
          end
        end
        default: ;
      endcase
    end
    check("strobes", 32'(obs_strobes()), 32'(es));
    check("state_led", 32'(state_led), 32'(m_state));
    check("digit_count", 32'(digit_count), 32'(m_cnt));
    check("mem_valid", 32'(mem_valid), 32'(m_memv));
    check("display", 32'(display_select), 32'(exp_disp(m_state)));
    check("error", 32'(error), 32'(m_state == S_ERR));
    m_state = ns; m_cnt = nc; m_memv = nm;
    @(posedge clock);
    #1;
    drive('0, 1'b0);
  endtask

  // Release reset with a digit key held; that cycle must produce nothing
  task automatic release_with_key(input string tag);
    @(negedge clock);
    drive(key(K_DIG), 1'b0);
    reset_n = 1'b1;
    #2;
    check({tag, "_strobes"}, 32'(obs_strobes()), 32'd0);
    @(posedge clock);
    #1;
    drive('0, 1'b0);
    check({tag, "_state"}, 32'(state_led), 32'd0);
    check({tag, "_count"}, 32'(digit_count), 32'd0);
    model_reset();
  endtask

  initial begin
    logic [8:0] k;
    int r;
    total = 0;
    bad = 0;
    model_reset();
    reset_n = 1'b0;
    drive('0, 1'b0);
    #3;
    check("rst_state", 32'(state_led), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_memv", 32'(mem_valid), 32'd0);
    check("rst_display", 32'(display_select), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    release_with_key("rel1");

    // Five digits: the fifth overflows and is dropped
    step(key(K_CLR), 1'b0);
    for (int i = 0; i < 5; i++) step(key(K_DIG), 1'b0);
    check("d5_state", 32'(state_led), 32'd1);
    check("d5_count", 32'(digit_count), 32'd4);

    // Sign toggling before the first digit of A
    step(key(K_CLR), 1'b0);
    step(key(K_SUB), 1'b0); check("neg1_state", 32'(state_led), 32'd2);
    step(key(K_SUB), 1'b0); check("neg2_state", 32'(state_led), 32'd0);
    step(key(K_SUB), 1'b0); check("neg3_state", 32'(state_led), 32'd2);
    step(key(K_DIG), 1'b0); check("neg_dig_state", 32'(state_led), 32'd1);

    // Full calculation, memory store, chained op and recall into B
    step(key(K_CLR), 1'b0);
    step(key(K_DIG), 1'b0);
    step(key(K_OP), 1'b0);
    step(key(K_DIG), 1'b0);
    step(key(K_EX), 1'b0);  check("exec_state", 32'(state_led), 32'd7);
    step('0, 1'b0);         check("res_state", 32'(state_led), 32'd6);
    check("res_display", 32'(display_select), 32'd2);
    step(key(K_MS), 1'b0);  check("ms_memv", 32'(mem_valid), 32'd1);
    step(key(K_OP), 1'b0);  check("chain_state", 32'(state_led), 32'd3);
    step(key(K_MR), 1'b0);  check("mr_state", 32'(state_led), 32'd4);
    check("mr_count", 32'(digit_count), 32'd4);

    // Datapath error path; only clear escapes and memory survives
    step(key(K_EX), 1'b0);
    step('0, 1'b1);         check("err_state", 32'(state_led), 32'd8);
    check("err_flag", 32'(error), 32'd1);
    check("err_display", 32'(display_select), 32'd3);
    step(key(K_DIG), 1'b0);
    step(key(K_OP), 1'b0);
    step(key(K_MR), 1'b0);
    step(key(K_MC), 1'b0);  check("err_hold", 32'(state_led), 32'd8);
    step(key(K_CLR), 1'b0); check("clr_state", 32'(state_led), 32'd0);
    check("clr_memv", 32'(mem_valid), 32'd1);

    // Simultaneous op+dig in OP_A, then backspace of the only digit
    step(key(K_DIG), 1'b0);
    step(key(K_OP) | key(K_DIG), 1'b0); check("opdig_state", 32'(state_led), 32'd3);
    step(key(K_CLR), 1'b0);
    step(key(K_DIG), 1'b0);
    step(key(K_BK), 1'b0);  check("bk_state", 32'(state_led), 32'd0);

    // Asynchronous reset mid-entry of B with three digits
    step(key(K_CLR), 1'b0);
    step(key(K_DIG), 1'b0);
    step(key(K_OP), 1'b0);
    for (int i = 0; i < 3; i++) step(key(K_DIG), 1'b0);
    @(negedge clock);
    drive(key(K_DIG), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state_led), 32'd0);
    check("arst_count", 32'(digit_count), 32'd0);
    check("arst_memv", 32'(mem_valid), 32'd0);
    check("arst_strobes", 32'(obs_strobes()), 32'd0);
    check("arst_display", 32'(display_select), 32'd0);
    release_with_key("rel2");

    // Randomized key traffic against the model
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) k = key(K_CLR);
      else begin
        k = key(int'($urandom_range(0, 7)));
        if ($urandom_range(0, 4) == 0) k = k | key(int'($urandom_range(0, 8)));
      end
      step(k, 1'($urandom_range(0, 1)));
    end
    step('0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
